// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with a small FIFO of
// long-latency results, tracks pending destinations, and flags hazards and misuse.
module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        hazard,
    output logic        stall_req,
    output logic        err,
    output logic        WE3,
    output logic [4:0]  WA3,
    output logic [31:0] WD3
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    logic [4:0]       mem_rd_q   [FIFO_DEPTH];
    logic [31:0]      mem_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pend_q, pend_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             err_q, err_d;

    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic        not_empty;
    logic        wb_grant;
    logic        accept;
    logic        push;
    logic        pop;
    logic        iss_set;

    assign head_rd   = mem_rd_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign wb_grant  = wb_valid && (wb_rd != 5'd0);
    assign iss_set   = iss_valid && (iss_rd != 5'd0);

    // Reset gating keeps the port and handshake quiet for the whole reset pulse.
    assign lu_ready = !reset && (count_q < DEPTH_C);
    assign accept   = lu_valid && lu_ready;
    assign push     = accept && (lu_rd != 5'd0);
    assign pop      = !reset && !wb_grant && not_empty;

    assign hazard    = pend_q[q_rs1] | pend_q[q_rs2] | pend_q[q_rd];
    assign stall_req = stall_q;
    assign err       = err_q;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        WE3 = 1'b0;
        WA3 = 5'd0;
        WD3 = 32'd0;
        if (!reset) begin
            if (wb_grant) begin
                WE3 = 1'b1;
                WA3 = wb_rd;
                WD3 = wb_data;
            end else if (not_empty) begin
                WE3 = 1'b1;
                WA3 = head_rd;
                WD3 = head_data;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pend_d   = pend_q;
        starve_d = starve_q;
        err_d    = err_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Clear before set so an issue on the same edge as the retiring write wins.
        if (pop)     pend_d[head_rd] = 1'b0;
        if (iss_set) pend_d[iss_rd]  = 1'b1;
        pend_d[0] = 1'b0;

        if (iss_set && pend_q[iss_rd] && !(pop && (head_rd == iss_rd))) err_d = 1'b1;
        if (push && !pend_q[lu_rd])                                     err_d = 1'b1;
        if (pop && !pend_q[head_rd])                                    err_d = 1'b1;

        if (!not_empty || pop)        starve_d = '0;
        else if (starve_q != LIMIT_C) starve_d = starve_q + STV_W'(1);

        stall_d = (starve_d == LIMIT_C);
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide what is valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= lu_rd;
            mem_data_q[wr_ptr_q] <= lu_data;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change just after the rising edge,
// outputs are sampled on the falling edge against hand-computed values.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_rs1, q_rs2, q_rd;
    logic        hazard, stall_req, err;
    logic        WE3;
    logic [4:0]  WA3;
    logic [31:0] WD3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
        .hazard(hazard), .stall_req(stall_req), .err(err),
        .WE3(WE3), .WA3(WA3), .WD3(WD3)
    );

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        iss_valid = 0; iss_rd = 0;
        q_rs1 = 0; q_rs2 = 0; q_rd = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1; iss_rd = rd;
        next_cycle();
        iss_valid = 0; iss_rd = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h1;
        q_rs1 = 5'd3; q_rs2 = 5'd4; q_rd = 5'd5;
        sample();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %0b want 0", WE3); end
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got %0b want 0", lu_ready); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b want 0", hazard); end
        checks++; if ({stall_req, err} !== 2'b00) begin errors++; $display("FAIL reset_stall_err got %b want 00", {stall_req, err}); end
        next_cycle();
        reset = 0;
        idle();
        sample();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", lu_ready); end
        next_cycle();
    endtask

    task automatic test_basic();
        issue(5'd5);
        q_rs2 = 5'd5;
        lu_valid = 1; lu_rd = 5'd5; lu_data = 32'hA5A5A5A5;
        sample();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL basic_hazard_set got %0b want 1", hazard); end
        checks++; if ({WE3, lu_ready} !== 2'b01) begin errors++; $display("FAIL basic_accept_cycle got we/ready %b want 01", {WE3, lu_ready}); end
        next_cycle();
        lu_valid = 0;
        sample();
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin errors++; $display("FAIL basic_write got we=%0b wa=%0d wd=%h want we=1 wa=5 wd=a5a5a5a5", WE3, WA3, WD3); end
        next_cycle();
        sample();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL basic_hazard_clear got %0b want 0", hazard); end
        checks++; if ({WE3, WA3, WD3} !== 38'd0) begin errors++; $display("FAIL basic_idle got we=%0b wa=%0d wd=%h want all zero", WE3, WA3, WD3); end
        q_rs2 = 0;
        next_cycle();
    endtask

    task automatic test_wb_priority();
        issue(5'd7);
        lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h77;
        next_cycle();
        lu_valid = 0;
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h33;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd3, 32'h33}) begin errors++; $display("FAIL prio_wb_%0d got we=%0b wa=%0d wd=%h want we=1 wa=3 wd=33", i, WE3, WA3, WD3); end
            checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL prio_stall_%0d got %0b want 0", i, stall_req); end
            next_cycle();
        end
        wb_valid = 0;
        sample();
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd7, 32'h77}) begin errors++; $display("FAIL prio_drain got we=%0b wa=%0d wd=%h want we=1 wa=7 wd=77", WE3, WA3, WD3); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL prio_stall_drain got %0b want 0", stall_req); end
        next_cycle();
        sample();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL prio_empty got %0b want 0", WE3); end
        next_cycle();
    endtask

    task automatic test_starve();
        issue(5'd8);
        lu_valid = 1; lu_rd = 5'd8; lu_data = 32'h88;
        next_cycle();
        lu_valid = 0;
        wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_early_%0d got %0b want 0", i, stall_req); end
            next_cycle();
        end
        sample();
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_assert got %0b want 1", stall_req); end
        next_cycle();
        // Writeback to x0 is dropped and must not block the FIFO drain.
        wb_rd = 5'd0; wb_data = 32'hDEAD;
        sample();
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd8, 32'h88}) begin errors++; $display("FAIL starve_x0_drain got we=%0b wa=%0d wd=%h want we=1 wa=8 wd=88", WE3, WA3, WD3); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_hold got %0b want 1", stall_req); end
        next_cycle();
        wb_valid = 0;
        sample();
        checks++; if ({stall_req, WE3} !== 2'b00) begin errors++; $display("FAIL starve_release got stall/we %b want 00", {stall_req, WE3}); end
        next_cycle();
    endtask

    task automatic test_full();
        issue(5'd10); issue(5'd11); issue(5'd12);
        wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h1;
        lu_valid = 1; lu_rd = 5'd10; lu_data = 32'h1010;
        sample();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready0 got %0b want 1", lu_ready); end
        next_cycle();
        lu_rd = 5'd11; lu_data = 32'h1111;
        sample();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got %0b want 1", lu_ready); end
        next_cycle();
        lu_rd = 5'd12; lu_data = 32'h1212;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_blocked_%0d got %0b want 0", i, lu_ready); end
            next_cycle();
        end
        wb_valid = 0;
        sample();
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %0b want 0", lu_ready); end
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd10, 32'h1010}) begin errors++; $display("FAIL full_pop10 got we=%0b wa=%0d wd=%h want we=1 wa=10 wd=1010", WE3, WA3, WD3); end
        next_cycle();
        sample();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got %0b want 1", lu_ready); end
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd11, 32'h1111}) begin errors++; $display("FAIL full_pop11 got we=%0b wa=%0d wd=%h want we=1 wa=11 wd=1111", WE3, WA3, WD3); end
        next_cycle();
        lu_valid = 0;
        sample();
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd12, 32'h1212}) begin errors++; $display("FAIL full_pop12 got we=%0b wa=%0d wd=%h want we=1 wa=12 wd=1212", WE3, WA3, WD3); end
        next_cycle();
        sample();
        checks++; if ({WE3, err} !== 2'b00) begin errors++; $display("FAIL full_end got we/err %b want 00", {WE3, err}); end
        next_cycle();
    endtask

    task automatic test_same_edge();
        issue(5'd13);
        lu_valid = 1; lu_rd = 5'd13; lu_data = 32'h1313;
        next_cycle();
        lu_valid = 0;
        iss_valid = 1; iss_rd = 5'd13;
        sample();
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd13, 32'h1313}) begin errors++; $display("FAIL same_pop got we=%0b wa=%0d wd=%h want we=1 wa=13 wd=1313", WE3, WA3, WD3); end
        next_cycle();
        iss_valid = 0; iss_rd = 0;
        q_rd = 5'd13;
        sample();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL same_set_wins got %0b want 1", hazard); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL same_no_err got %0b want 0", err); end
        lu_valid = 1; lu_rd = 5'd13; lu_data = 32'h131313;
        next_cycle();
        lu_valid = 0;
        sample();
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd13, 32'h131313}) begin errors++; $display("FAIL same_second got we=%0b wa=%0d wd=%h want we=1 wa=13 wd=131313", WE3, WA3, WD3); end
        next_cycle();
        sample();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL same_cleared got %0b want 0", hazard); end
        q_rd = 0;
        next_cycle();
    endtask

    task automatic test_discard();
        lu_valid = 1; lu_rd = 5'd0; lu_data = 32'hFFFF;
        sample();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL discard_ready got %0b want 1", lu_ready); end
        next_cycle();
        lu_valid = 0;
        sample();
        checks++; if ({WE3, err} !== 2'b00) begin errors++; $display("FAIL discard_nowrite got we/err %b want 00", {WE3, err}); end
        next_cycle();
    endtask

    task automatic test_hazard_err();
        issue(5'd9);
        sample();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_x0 got %0b want 0", hazard); end
        q_rs2 = 5'd9;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_rs2 got %0b want 1", hazard); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL hz_err_pre got %0b want 0", err); end
        next_cycle();
        issue(5'd9);
        sample();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL hz_err_set got %0b want 1", err); end
        next_cycle();
        next_cycle();
        sample();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL hz_err_sticky got %0b want 1", err); end
        q_rs2 = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        issue(5'd20); issue(5'd21);
        wb_valid = 1; wb_rd = 5'd2; wb_data = 32'h2;
        lu_valid = 1; lu_rd = 5'd20; lu_data = 32'h2020;
        next_cycle();
        lu_rd = 5'd21; lu_data = 32'h2121;
        next_cycle();
        lu_valid = 0; wb_valid = 0;
        q_rs1 = 5'd20; q_rs2 = 5'd21;
        #2;
        checks++; if ({WE3, WA3, WD3} !== {1'b1, 5'd20, 32'h2020}) begin errors++; $display("FAIL rmid_head got we=%0b wa=%0d wd=%h want we=1 wa=20 wd=2020", WE3, WA3, WD3); end
        reset = 1;
        #1;
        checks++; if ({WE3, lu_ready, hazard} !== 3'b000) begin errors++; $display("FAIL rmid_immediate got we/ready/hazard %b want 000", {WE3, lu_ready, hazard}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err_clear got %0b want 0", err); end
        sample();
        reset = 0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            checks++; if ({WE3, lu_ready, hazard} !== 3'b010) begin errors++; $display("FAIL rmid_after_%0d got we/ready/hazard %b want 010", i, {WE3, lu_ready, hazard}); end
        end
        next_cycle();
        q_rs1 = 0; q_rs2 = 5'd9;
        issue(5'd9);
        sample();
        checks++; if ({hazard, err} !== 2'b10) begin errors++; $display("FAIL rmid_fresh_issue got hazard/err %b want 10", {hazard, err}); end
        next_cycle();
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wb_priority();
        test_starve();
        test_full();
        test_same_edge();
        test_discard();
        test_hazard_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
